// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA sync decoder.
package vga_pkg;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_LOCK_FRAMES = 2;
  localparam int CNT_W           = 12;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_LOCKED
  } vga_state_e;

  typedef struct packed {
    logic       blank;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vga_pix_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       pix_valid;
    logic       frame_start;
    logic       locked;
    logic       err;
  } vga_out_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registers one active-low sync input and flags its falling edge.
module vga_edge_det (
  input  logic i_VGA_CLK,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_level,
  output logic o_fall
);

  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    sync_d = i_sync;
    prev_d = sync_q;
  end

  // Reset to 0 so a sync line already low at release cannot fake an edge.
  always_ff @(posedge i_VGA_CLK) begin
    if (!i_rst_n) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q;
  assign o_fall  = prev_q & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from VGA sync/blank, validates timing and locks.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic       i_VGA_CLK,
  input  logic       i_rst_n,
  input  logic       i_VGA_HS,
  input  logic       i_VGA_VS,
  input  logic       i_BLANK_N,
  input  logic [7:0] i_VGA_R,
  input  logic [7:0] i_VGA_G,
  input  logic [7:0] i_VGA_B,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_pix_valid,
  output logic [7:0] o_R,
  output logic [7:0] o_G,
  output logic [7:0] o_B,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err
);

  localparam logic [CNT_W-1:0] H_TOT_C = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOT_C = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_FRAMES);
  localparam logic [9:0]       H_ACT_X = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT_Y = 10'(V_ACTIVE);

  logic hs_lvl, hs_edge, vs_lvl, vs_edge;

  vga_pix_t   in_d, in_q;
  vga_state_e state_d, state_q;
  vga_out_t   out_d, out_q;
  logic [CNT_W-1:0] h_cnt_d, h_cnt_q, l_cnt_d, l_cnt_q, good_d, good_q;
  logic [CNT_W-1:0] l_close, good_inc;
  logic [9:0] x_cnt_d, x_cnt_q, y_cnt_d, y_cnt_q, y_close;
  logic fs_pend_d, fs_pend_q;
  logic line_act, viol;

  vga_edge_det u_hs (.i_VGA_CLK(i_VGA_CLK), .i_rst_n(i_rst_n), .i_sync(i_VGA_HS),
                     .o_level(hs_lvl), .o_fall(hs_edge));
  vga_edge_det u_vs (.i_VGA_CLK(i_VGA_CLK), .i_rst_n(i_rst_n), .i_sync(i_VGA_VS),
                     .o_level(vs_lvl), .o_fall(vs_edge));

  // x_cnt doubles as the per-line pixel count and y_cnt as the active-line count.
  // On a coincident HS+VS edge the line closes into l_close/y_close before the
  // frame is checked, then both restart for line 0.
  always_comb begin
    in_d     = '{blank: i_BLANK_N, r: i_VGA_R, g: i_VGA_G, b: i_VGA_B};
    line_act = (x_cnt_q != '0);
    l_close  = hs_edge ? sat_inc(l_cnt_q) : l_cnt_q;
    y_close  = (hs_edge && line_act) ? ((&y_cnt_q) ? y_cnt_q : y_cnt_q + 10'd1) : y_cnt_q;
    viol     = (hs_edge && (h_cnt_q != H_TOT_C || (line_act && x_cnt_q != H_ACT_X)))
            || (vs_edge && (l_close != V_TOT_C || y_close != V_ACT_Y))
            || (in_q.blank && (x_cnt_q == H_ACT_X || !hs_lvl || !vs_lvl));
    h_cnt_d  = hs_edge ? CNT_W'(1) : sat_inc(h_cnt_q);
    l_cnt_d  = vs_edge ? '0 : l_close;
    x_cnt_d  = hs_edge ? '0 : (in_q.blank ? ((&x_cnt_q) ? x_cnt_q : x_cnt_q + 10'd1) : x_cnt_q);
    y_cnt_d  = vs_edge ? '0 : y_close;
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    good_inc = sat_inc(good_q);
    case (state_q)
      ST_SEARCH: begin
        good_d = '0;
        if (vs_edge) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (viol) state_d = ST_SEARCH;
        else if (vs_edge) begin
          if (good_inc >= LOCK_C) state_d = ST_LOCKED;
          else good_d = good_inc;
        end
      end
      ST_LOCKED: if (viol) state_d = ST_SEARCH;
      default:   state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    out_d             = out_q;
    out_d.pix_valid   = 1'b0;
    out_d.frame_start = 1'b0;
    out_d.locked      = (state_q == ST_LOCKED);
    out_d.err         = viol && (state_q != ST_SEARCH);
    if (state_q == ST_LOCKED && in_q.blank && !viol) begin
      out_d.pix_valid   = 1'b1;
      out_d.frame_start = fs_pend_q;
      out_d.x           = x_cnt_q;
      out_d.y           = y_cnt_q;
      out_d.r           = in_q.r;
      out_d.g           = in_q.g;
      out_d.b           = in_q.b;
    end
    fs_pend_d = vs_edge ? 1'b1 : (out_d.pix_valid ? 1'b0 : fs_pend_q);
  end

  always_ff @(posedge i_VGA_CLK) begin
    if (!i_rst_n) begin
      in_q      <= '0;
      state_q   <= ST_SEARCH;
      good_q    <= '0;
      h_cnt_q   <= '0;
      l_cnt_q   <= '0;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      fs_pend_q <= 1'b0;
      out_q     <= '0;
    end else begin
      in_q      <= in_d;
      state_q   <= state_d;
      good_q    <= good_d;
      h_cnt_q   <= h_cnt_d;
      l_cnt_q   <= l_cnt_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      fs_pend_q <= fs_pend_d;
      out_q     <= out_d;
    end
  end

  assign o_x           = out_q.x;
  assign o_y           = out_q.y;
  assign o_R           = out_q.r;
  assign o_G           = out_q.g;
  assign o_B           = out_q.b;
  assign o_pix_valid   = out_q.pix_valid;
  assign o_frame_start = out_q.frame_start;
  assign o_locked      = out_q.locked;
  assign o_err         = out_q.err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a scaled-down raster (48x24, 32x16 active).
module tb_vga_sync_decoder;

  localparam int H_T = 48, V_T = 24, H_A = 32, V_A = 16;
  localparam int HS_W = 4, H_BP = 8, VS_W = 2, V_BP = 4;
  localparam int M_CLEAN = 0, M_SHORT = 1, M_LONG = 2, M_RST = 3;
  localparam int SHORT_LN = 6, LONG_LN = 8, RST_LN = 10;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic       rst_n, hs, vs, bl;
  logic [7:0] r, g, b;
  logic [9:0] o_x, o_y;
  logic [7:0] o_R, o_G, o_B;
  logic       o_pix_valid, o_frame_start, o_locked, o_err;

  vga_sync_decoder #(.H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .V_ACTIVE(V_A),
                     .LOCK_FRAMES(2)) dut (
    .i_VGA_CLK(gclk), .i_rst_n(rst_n), .i_VGA_HS(hs), .i_VGA_VS(vs), .i_BLANK_N(bl),
    .i_VGA_R(r), .i_VGA_G(g), .i_VGA_B(b), .o_x(o_x), .o_y(o_y), .o_pix_valid(o_pix_valid),
    .o_R(o_R), .o_G(o_G), .o_B(o_B), .o_frame_start(o_frame_start), .o_locked(o_locked),
    .o_err(o_err));

  int n_chk = 0, n_fail = 0, cyc = 0, npix = 0;
  logic [63:0] pq[$];
  int eq[$];

  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h @cyc %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int c, input logic [9:0] x, input logic [9:0] y,
                                     input logic [7:0] cr, input logic [7:0] cg,
                                     input logic [7:0] cb, input logic fs);
    return {3'b0, c[15:0], x, y, cr, cg, cb, fs};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({o_x, o_y, o_R, o_G, o_B, o_pix_valid, o_frame_start, o_locked, o_err});
  endfunction

  // Outputs are sampled on the falling edge, well away from the active edge.
  always @(negedge gclk) begin : mon
    logic [63:0] e;
    int ec;
    if (o_pix_valid) begin
      npix++;
      if (pq.size() == 0) chk("pix_unexp", 64'(o_pix_valid), 64'd0);
      else begin
        e = pq.pop_front();
        chk("pix", pk(cyc, o_x, o_y, o_R, o_G, o_B, o_frame_start), e);
      end
    end else if (o_frame_start) chk("fs_nopix", 64'(o_frame_start), 64'd0);
    if (o_err) begin
      if (eq.size() == 0) chk("err_unexp", 64'(o_err), 64'd0);
      else begin
        ec = eq.pop_front();
        chk("err_cyc", 64'(cyc), 64'(ec));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      hs = 1'b1; vs = 1'b1; bl = 1'b0; r = 8'h0; g = 8'h0; b = 8'h0;
      @(posedge gclk); #1;
    end
  endtask

  task automatic run_frame(input int mode, input bit push, input bit lock_chk);
    bit first = 1'b1;
    bit live  = push;
    for (int ln = 0; ln < V_T; ln++) begin
      int len = (mode == M_SHORT && ln == SHORT_LN) ? H_T - 1 : H_T;
      for (int h = 0; h < len; h++) begin
        logic [7:0] px, la;
        px = 8'(h - H_BP);
        la = 8'(ln - V_BP);
        if (lock_chk && ln == 0 && h == 2) chk("lock_pre", 64'(o_locked), 64'd0);
        if (lock_chk && ln == 0 && h == 3) chk("lock_rise", 64'(o_locked), 64'd1);
        if (mode == M_SHORT && ln == SHORT_LN + 1 && h == 2) chk("lock_hold", 64'(o_locked), 64'd1);
        if (mode == M_SHORT && ln == SHORT_LN + 1 && h == 3) chk("lock_fall", 64'(o_locked), 64'd0);
        if (mode == M_RST && ln == RST_LN && h == 1) chk("rst_mid", outs(), 64'd0);
        hs = (h >= HS_W);
        vs = (ln >= VS_W);
        bl = (ln >= V_BP && ln < V_BP + V_A && h >= H_BP && h < H_BP + H_A);
        if (mode == M_LONG && ln == LONG_LN && h == H_BP + H_A) begin
          bl = 1'b1; live = 1'b0; eq.push_back(cyc + 2);
        end
        if (mode == M_SHORT && ln == SHORT_LN + 1 && h == 0) begin
          live = 1'b0; eq.push_back(cyc + 2);
        end
        if (mode == M_RST && ln == RST_LN && h == 0) begin rst_n = 1'b0; live = 1'b0; end
        if (mode == M_RST && ln == RST_LN && h == 5) rst_n = 1'b1;
        if (bl) begin
          r = la; g = px ^ la; b = px;
        end else begin
          r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
        if (bl && live) begin
          pq.push_back(pk(cyc + 2, 10'(px), 10'(la), la, px ^ la, px, first));
          first = 1'b0;
        end
        @(posedge gclk); #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle(4);
    chk("rst_outs", outs(), 64'd0);
    chk("rst_lock", 64'(o_locked), 64'd0);
    rst_n = 1'b1;
    idle(10);
    // Two aligning frames, then the third is locked and fully scoreboarded.
    run_frame(M_CLEAN, 1'b0, 1'b0);
    run_frame(M_CLEAN, 1'b0, 1'b0);
    npix = 0;
    run_frame(M_CLEAN, 1'b1, 1'b1);
    chk("frame_pix", 64'(npix), 64'(H_A * V_A));
    run_frame(M_SHORT, 1'b1, 1'b0);
    run_frame(M_CLEAN, 1'b0, 1'b0);
    run_frame(M_CLEAN, 1'b0, 1'b0);
    run_frame(M_LONG, 1'b1, 1'b1);
    run_frame(M_CLEAN, 1'b0, 1'b0);
    run_frame(M_CLEAN, 1'b0, 1'b0);
    run_frame(M_RST, 1'b1, 1'b1);
    run_frame(M_CLEAN, 1'b0, 1'b0);
    run_frame(M_CLEAN, 1'b0, 1'b0);
    npix = 0;
    run_frame(M_CLEAN, 1'b1, 1'b1);
    idle(10);
    chk("frame_pix_relock", 64'(npix), 64'(H_A * V_A));
    chk("pix_left", 64'(pq.size()), 64'd0);
    chk("err_left", 64'(eq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-003 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames to lock.
REQ-006 SHALL have ports, in order:
- i_VGA_CLK  in  1  pixel clock.
- i_rst_n  in  1  reset: synchronous, active-low, on i_VGA_CLK.
- i_VGA_HS, i_VGA_VS  in  1 each  sync inputs, active-low.
- i_BLANK_N  in  1  data enable, high = active pixel.
- i_VGA_R, i_VGA_G, i_VGA_B  in  8 each  pixel colour.
- o_x, o_y  out  10 each  recovered pixel coordinates.
- o_pix_valid  out  1  o_x/o_y/o_R/G/B hold a qualified active pixel.
- o_R, o_G, o_B  out  8 each  pixel colour, aligned with o_pix_valid.
- o_frame_start  out  1  one-cycle pulse at the first active pixel of a frame.
- o_locked  out  1  timing matches parameters.
- o_err  out  1  one-cycle pulse on any timing violation.

Function
REQ-007 SHALL register all inputs once; every output SHALL be registered and SHALL appear exactly 2 cycles after the input sample that produced it.
REQ-008 SHALL detect an HS edge as a registered 1->0 transition of i_VGA_HS, and a VS edge likewise for i_VGA_VS.
REQ-009 SHALL count clocks between HS edges; at each HS edge the count SHALL equal H_TOTAL, otherwise a violation is raised.
REQ-010 SHALL count BLANK_N-high clocks per line; lines with a nonzero count SHALL be active lines, and each active line's count SHALL equal H_ACTIVE.
REQ-011 SHALL count HS edges and active lines between VS edges; at each VS edge they SHALL equal V_TOTAL and V_ACTIVE respectively.
REQ-012 SHALL reset o_x to 0 at every HS edge and increment it after each active pixel.
REQ-013 SHALL reset o_y to 0 at every VS edge and increment it at the HS edge that closes an active line.
REQ-014 SHALL saturate the internal line, pixel and frame counters at all-ones; no wrap-around.
REQ-015 SHALL use FSM states:
- SEARCH: wait for a VS edge, then go to ALIGN.
- ALIGN: count good frames; go to LOCKED at LOCK_FRAMES good frames, or to SEARCH on any violation.
- LOCKED: remain while no violation; any violation goes to SEARCH.
REQ-016 SHALL hold o_locked high only in LOCKED.
REQ-017 SHALL assert o_pix_valid only in LOCKED with registered BLANK_N high, and SHALL hold o_x/o_y/colour at their last values otherwise.
REQ-018 SHALL pulse o_err for one cycle at the edge where a violation is detected, in ALIGN or LOCKED only; never in SEARCH.
REQ-019 SHALL detect violations (REQ-009..011, REQ-020) at the closing edge, except that BLANK_N high while the pixel count already equals H_ACTIVE SHALL be flagged immediately.
REQ-020 SHALL treat BLANK_N high during HS low or VS low as a violation.
REQ-021 SHALL, on simultaneous HS and VS edges, close the line first, then close the frame, then open line 0 of the new frame.
REQ-022 SHALL pulse o_frame_start with the first o_pix_valid after a VS edge, and only in LOCKED.

Reset
REQ-023 SHALL, while i_rst_n is low, set: o_x=0, o_y=0, o_R/G/B=0, o_pix_valid=0, o_frame_start=0, o_locked=0, o_err=0, all counters 0, FSM=SEARCH.
REQ-024 SHALL treat a reset mid-frame as a full restart: relock requires a fresh VS edge plus LOCK_FRAMES good frames.

Structure
REQ-025 SHALL place the FSM state enum and the 480p default timing constants in shared package vga_pkg.
REQ-026 SHALL use one sub-module, vga_edge_det: registers a sync input and outputs its falling-edge pulse; instantiated twice (HS, VS).

Verification
REQ-027 Feed 3 frames of clean 800x525/640x480 timing after reset -> o_locked rises at the VS edge ending frame 2; frame 3 yields 307200 o_pix_valid cycles, first at (0,0), last at (639,479).
REQ-028 Drive pixel colour = {Sy[7:0], Sx[7:0] ^ Sy[7:0], Sx[7:0]} -> every valid output satisfies o_R=o_y[7:0] and o_B=o_x[7:0], 2-cycle latency.
REQ-029 While locked, shorten one line to 799 clocks -> o_err pulses once at that HS edge, o_locked falls next cycle, and o_pix_valid stays 0 until relock.
REQ-030 While locked, hold BLANK_N high for 641 clocks -> o_err pulses on the 641st pixel sample and the FSM goes to SEARCH.
REQ-031 Assert reset at line 200 of a locked frame -> all outputs 0 next cycle; no o_err in the partial frame; o_locked returns after 2 full frames.
REQ-032 Coincide HS and VS edges -> no violation; o_y restarts at 0 and the frame line count is 525.
